// File: rtl/hafsa_sopc_input_debounce_if.sv
// Pin-conditioning bundle between raw board inputs and the SOPC input PIO.
interface hafsa_sopc_input_debounce_if #(
  parameter int unsigned WIDTH = 2
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (output raw_in, input clean_out, rise_pulse, fall_pulse);
  modport slave  (input raw_in, output clean_out, rise_pulse, fall_pulse);
endinterface

// File: rtl/hafsa_sopc_input_debounce.sv
// Per-channel 2-flop synchroniser plus debounce FSM; emits stable levels and
// one-cycle rise/fall strobes for the SOPC input PIO.
module hafsa_sopc_input_debounce #(
  parameter int unsigned     WIDTH           = 2,
  parameter int unsigned     DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  hafsa_sopc_input_debounce_if.slave io
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE, SETTLING} state_e;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  // Registers: synchroniser, per-channel FSM/counter, and outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= INIT_VALUE;
      sync2_q <= INIT_VALUE;
      clean_q <= INIT_VALUE;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= io.raw_in;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state: a new level must be seen DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i] != clean_q[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              clean_d[i] = sync2_q[i];
              rise_d[i]  = sync2_q[i];
              fall_d[i]  = ~sync2_q[i];
            end else begin
              cnt_d[i]   = CNT_W'(1);
              state_d[i] = SETTLING;
            end
          end
        end
        SETTLING: begin
          if (sync2_q[i] == clean_q[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = STABLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            clean_d[i] = sync2_q[i];
            rise_d[i]  = sync2_q[i];
            fall_d[i]  = ~sync2_q[i];
            cnt_d[i]   = '0;
            state_d[i] = STABLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = STABLE;
        end
      endcase
    end
  end

  assign io.clean_out  = clean_q;
  assign io.rise_pulse = rise_q;
  assign io.fall_pulse = fall_q;

endmodule
